// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I decode stage: opcodes, immediate formats and the ID/EX payload.
// Also provides the opcode-to-format and legality lookups used by decode and imm_gen.
package decode_stage_pkg;

  typedef logic [31:0] Word;
  typedef logic [4:0]  RegAddress;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_OPIMM  = 7'b0010011,
    OP_OP     = 7'b0110011
  } opcode_t;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_format_t;

  typedef struct packed {
    Word        pc;
    Word        rs1_val;
    Word        rs2_val;
    Word        imm;
    RegAddress  rd;
    RegAddress  rs1;
    RegAddress  rs2;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       is_load;
    logic       writes_rd;
    logic       illegal;
  } id_ex_t;

  // Unknown opcodes fall into FMT_R so they carry a zero immediate.
  function automatic imm_format_t imm_format(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_OPIMM, OP_JALR: return FMT_I;
      OP_STORE:                   return FMT_S;
      OP_BRANCH:                  return FMT_B;
      OP_LUI, OP_AUIPC:           return FMT_U;
      OP_JAL:                     return FMT_J;
      default:                    return FMT_R;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] opcode);
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: selects the RV32I immediate layout from the opcode
// and sign-extends from instr[31]; R-type and unknown opcodes yield zero.
module imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output Word         imm
);

  always_comb begin
    imm = '0;
    case (imm_format(instr[6:0]))
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage: decodes one instruction per cycle, bypasses the
// coinciding write-back, stalls one bubble on load-use, and holds a handshaked ID/EX register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter bit WB_BYPASS      = 1'b1,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  Word         in_pc,
  input  logic        flush,
  output RegAddress   rf_addr1,
  output RegAddress   rf_addr2,
  input  Word         rf_out1,
  input  Word         rf_out2,
  input  logic        wb_we,
  input  RegAddress   wb_addr,
  input  Word         wb_data,
  input  logic        ex_ready,
  output logic        out_valid,
  output Word         out_pc,
  output Word         out_rs1_val,
  output Word         out_rs2_val,
  output Word         out_imm,
  output RegAddress   out_rd,
  output RegAddress   out_rs1,
  output RegAddress   out_rs2,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic        out_is_load,
  output logic        out_writes_rd,
  output logic        out_illegal
);

  logic [6:0] opcode;
  RegAddress  rs1;
  RegAddress  rs2;
  RegAddress  rd;
  Word        imm;
  Word        rs1_val;
  Word        rs2_val;
  logic       legal;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       hazard;
  logic       valid_q;
  id_ex_t     idex_q;
  id_ex_t     idex_next;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign legal  = is_legal(opcode);

  assign rf_addr1 = rs1;
  assign rf_addr2 = rs2;

  imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (imm)
  );

  // x0 reads as zero even when write-back targets it.
  assign rs1_val = (rs1 == '0) ? '0 :
                   (WB_BYPASS && wb_we && (wb_addr == rs1)) ? wb_data : rf_out1;
  assign rs2_val = (rs2 == '0) ? '0 :
                   (WB_BYPASS && wb_we && (wb_addr == rs2)) ? wb_data : rf_out2;

  assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign uses_rs2 = (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign hazard = LOAD_USE_STALL && valid_q && idex_q.is_load && (idex_q.rd != '0) &&
                  ((uses_rs1 && (rs1 == idex_q.rd)) || (uses_rs2 && (rs2 == idex_q.rd)));

  assign in_ready = !flush && !hazard && (!valid_q || ex_ready);

  always_comb begin
    idex_next           = '0;
    idex_next.pc        = in_pc;
    idex_next.rs1_val   = rs1_val;
    idex_next.rs2_val   = rs2_val;
    idex_next.imm       = imm;
    idex_next.rd        = rd;
    idex_next.rs1       = rs1;
    idex_next.rs2       = rs2;
    idex_next.opcode    = opcode;
    idex_next.funct3    = in_instr[14:12];
    idex_next.funct7b5  = in_instr[30];
    idex_next.is_load   = (opcode == OP_LOAD);
    idex_next.writes_rd = legal && (opcode != OP_STORE) && (opcode != OP_BRANCH) && (rd != '0);
    idex_next.illegal   = !legal;
  end

  // A stall with ex_ready high drains ID/EX, which is what produces the single bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      idex_q  <= idex_next;
    end else if (ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = idex_q.pc;
  assign out_rs1_val   = idex_q.rs1_val;
  assign out_rs2_val   = idex_q.rs2_val;
  assign out_imm       = idex_q.imm;
  assign out_rd        = idex_q.rd;
  assign out_rs1       = idex_q.rs1;
  assign out_rs2       = idex_q.rs2;
  assign out_opcode    = idex_q.opcode;
  assign out_funct3    = idex_q.funct3;
  assign out_funct7b5  = idex_q.funct7b5;
  assign out_is_load   = idex_q.is_load;
  assign out_writes_rd = idex_q.writes_rd;
  assign out_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push hand-decoded ID/EX
// contents into a queue that a negedge monitor drains whenever execute takes an entry.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  Word         in_pc;
  logic        flush;
  RegAddress   rf_addr1, rf_addr2;
  Word         rf_out1, rf_out2;
  logic        wb_we;
  RegAddress   wb_addr;
  Word         wb_data;
  logic        ex_ready;
  logic        out_valid;
  Word         out_pc, out_rs1_val, out_rs2_val, out_imm;
  RegAddress   out_rd, out_rs1, out_rs2;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_is_load, out_writes_rd, out_illegal;

  logic        nb_in_ready, nb_out_valid;
  RegAddress   nb_rf_addr1, nb_rf_addr2;
  Word         nb_out_pc, nb_out_rs1_val, nb_out_rs2_val, nb_out_imm;
  RegAddress   nb_out_rd, nb_out_rs1, nb_out_rs2;
  logic [6:0]  nb_out_opcode;
  logic [2:0]  nb_out_funct3;
  logic        nb_out_funct7b5, nb_out_is_load, nb_out_writes_rd, nb_out_illegal;

  logic [31:0] ig_instr;
  Word         ig_imm;

  int          total = 0;
  int          bad = 0;
  id_ex_t      exp_q[$];
  id_ex_t      mon_got;
  id_ex_t      mon_exp;

  decode_stage #(.WB_BYPASS(1'b1), .LOAD_USE_STALL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_out1(rf_out1), .rf_out2(rf_out2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val), .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .out_is_load(out_is_load),
    .out_writes_rd(out_writes_rd), .out_illegal(out_illegal)
  );

  decode_stage #(.WB_BYPASS(1'b0), .LOAD_USE_STALL(1'b1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nb_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .rf_addr1(nb_rf_addr1), .rf_addr2(nb_rf_addr2), .rf_out1(rf_out1), .rf_out2(rf_out2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready),
    .out_valid(nb_out_valid), .out_pc(nb_out_pc), .out_rs1_val(nb_out_rs1_val),
    .out_rs2_val(nb_out_rs2_val), .out_imm(nb_out_imm), .out_rd(nb_out_rd),
    .out_rs1(nb_out_rs1), .out_rs2(nb_out_rs2), .out_opcode(nb_out_opcode),
    .out_funct3(nb_out_funct3), .out_funct7b5(nb_out_funct7b5),
    .out_is_load(nb_out_is_load), .out_writes_rd(nb_out_writes_rd),
    .out_illegal(nb_out_illegal)
  );

  imm_gen u_ig (
    .instr (ig_instr),
    .imm   (ig_imm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic id_ex_t mk(input Word pc, input Word rs1v, input Word rs2v, input Word imm,
                                input RegAddress rd, input RegAddress rs1, input RegAddress rs2,
                                input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic ld, input logic wr, input logic ill);
    id_ex_t e;
    e.pc = pc; e.rs1_val = rs1v; e.rs2_val = rs2v; e.imm = imm;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.opcode = opc; e.funct3 = f3;
    e.funct7b5 = f7; e.is_load = ld; e.writes_rd = wr; e.illegal = ill;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Presents one instruction until accepted; the expected entry is queued at acceptance.
  task automatic applyStimulus(input logic [31:0] instr, input Word pc, input Word r1,
                               input Word r2, input id_ex_t exp);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1; in_instr = instr; in_pc = pc; rf_out1 = r1; rf_out2 = r2;
    for (int n = 0; n < 20 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        exp_q.push_back(exp);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout pc=%h: in_ready never high", pc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: execute takes an entry on a rising edge where out_valid and ex_ready are both high.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && ex_ready) begin
        mon_got = mk(out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_rs1, out_rs2,
                     out_opcode, out_funct3, out_funct7b5, out_is_load, out_writes_rd, out_illegal);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_output: got %h with empty scoreboard", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            bad++;
            $display("[TB] FAIL idex pc=%h: got pc=%h rs1v=%h rs2v=%h imm=%h rd=%0d wr=%b ill=%b raw=%h, expected pc=%h rs1v=%h rs2v=%h imm=%h rd=%0d wr=%b ill=%b raw=%h",
                     mon_exp.pc, mon_got.pc, mon_got.rs1_val, mon_got.rs2_val, mon_got.imm,
                     mon_got.rd, mon_got.writes_rd, mon_got.illegal, mon_got,
                     mon_exp.pc, mon_exp.rs1_val, mon_exp.rs2_val, mon_exp.imm,
                     mon_exp.rd, mon_exp.writes_rd, mon_exp.illegal, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    rf_out1 = '0; rf_out2 = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
    ig_instr = '0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    // Standalone immediate generator vectors.
    ig_instr = 32'h00208463; #1 checkOutput("imm_beq_pos8", ig_imm, 32'h00000008);
    ig_instr = 32'hFE001FE3; #1 checkOutput("imm_bne_neg2", ig_imm, 32'hFFFFFFFE);
    ig_instr = 32'hFFDFF06F; #1 checkOutput("imm_jal_neg4", ig_imm, 32'hFFFFFFFC);
    ig_instr = 32'hFE20AE23; #1 checkOutput("imm_sw_neg4", ig_imm, 32'hFFFFFFFC);
    ig_instr = 32'h123453B7; #1 checkOutput("imm_lui", ig_imm, 32'h12345000);
    ig_instr = 32'h00318333; #1 checkOutput("imm_rtype", ig_imm, 32'h00000000);

    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic decode");
    applyStimulus(32'h00700293, 32'h100, 32'h999, 32'h33,
      mk(32'h100, 32'h0, 32'h33, 32'h7, 5'd5, 5'd0, 5'd7, 7'h13, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    applyStimulus(32'hFE20AE23, 32'h104, 32'h100, 32'h22,
      mk(32'h104, 32'h100, 32'h22, 32'hFFFFFFFC, 5'd28, 5'd1, 5'd2, 7'h23, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0));

    $display("[TB] write-back bypass");
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    applyStimulus(32'h00318333, 32'h108, 32'h11, 32'h11,
      mk(32'h108, 32'h55, 32'h55, 32'h0, 5'd6, 5'd3, 5'd3, 7'h33, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    checkOutput("nobypass_rs1", nb_out_rs1_val, 32'h11);
    checkOutput("nobypass_rs2", nb_out_rs2_val, 32'h11);
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;

    $display("[TB] jal, branch, illegal");
    applyStimulus(32'hFFDFF06F, 32'h10C, 32'h1, 32'h2,
      mk(32'h10C, 32'h1, 32'h2, 32'hFFFFFFFC, 5'd0, 5'd31, 5'd29, 7'h6F, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0));
    applyStimulus(32'h00208463, 32'h110, 32'hA0, 32'hB0,
      mk(32'h110, 32'hA0, 32'hB0, 32'h8, 5'd8, 5'd1, 5'd2, 7'h63, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    applyStimulus(32'hFFFFFFFF, 32'h114, 32'h3, 32'h4,
      mk(32'h114, 32'h3, 32'h4, 32'h0, 5'd31, 5'd31, 5'd31, 7'h7F, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1));
    idle(2);

    $display("[TB] load-use stall");
    applyStimulus(32'h0000A203, 32'h200, 32'h1000, 32'h5,
      mk(32'h200, 32'h1000, 32'h0, 32'h0, 5'd4, 5'd1, 5'd0, 7'h03, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0));
    in_valid = 1'b1; in_instr = 32'h00220333; in_pc = 32'h204; rf_out1 = 32'h40; rf_out2 = 32'h20;
    @(negedge clk);
    checkOutput("loaduse_stall_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("loaduse_bubble_valid", 32'(out_valid), 32'd0);
    checkOutput("loaduse_resume_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(mk(32'h204, 32'h40, 32'h20, 32'h0, 5'd6, 5'd4, 5'd2, 7'h33, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);

    $display("[TB] backpressure then flush");
    ex_ready = 1'b0;
    applyStimulus(32'h123453B7, 32'h300, 32'hA, 32'hB,
      mk(32'h300, 32'hA, 32'hB, 32'h12345000, 5'd7, 5'd8, 5'd3, 7'h37, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0));
    in_valid = 1'b1; in_instr = 32'hFFF48493; in_pc = 32'h304; rf_out1 = 32'h10; rf_out2 = 32'h77;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_hold_pc", out_pc, 32'h300);
      @(posedge clk); #1;
    end
    flush = 1'b1; ex_ready = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    applyStimulus(32'hFFF48493, 32'h400, 32'h10, 32'h77,
      mk(32'h400, 32'h10, 32'h77, 32'hFFFFFFFF, 5'd9, 5'd9, 5'd31, 7'h13, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    idle(2);

    $display("[TB] asynchronous reset");
    ex_ready = 1'b0;
    applyStimulus(32'h00208463, 32'h600, 32'hA0, 32'hB0,
      mk(32'h600, 32'hA0, 32'hB0, 32'h8, 5'd8, 5'd1, 5'd2, 7'h63, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    checkOutput("prereset_valid", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_pc", out_pc, 32'h0);
    exp_q.delete();
    @(negedge clk); #2 rst_n = 1'b1; ex_ready = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h00700293, 32'h500, 32'h999, 32'h33,
      mk(32'h500, 32'h0, 32'h33, 32'h7, 5'd5, 5'd0, 5'd7, 7'h13, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    idle(3);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
